// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Define DIVIDER_SIGNED_EN for two's-complement division; unsigned otherwise.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Bits needed for an iteration counter that starts at width and counts down to 1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_seq_subtractor.sv
// Ripple-carry subtractor: d = x + ~y + 1. The carry-out is high when x >= y, i.e. no borrow.
module subtractor_nbits #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] d_o,
    output logic             no_borrow_o
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] y_inv;

    assign carry[0] = 1'b1;
    assign y_inv    = ~y_i;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign d_o[gi]      = x_i[gi] ^ y_inv[gi] ^ carry[gi];
        assign carry[gi+1]  = (x_i[gi] & y_inv[gi]) | (carry[gi] & (x_i[gi] ^ y_inv[gi]));
    end

    assign no_borrow_o = carry[WIDTH];

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_SIGNED_EN for signed operands (magnitude division, truncation toward zero).
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(1);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] quo_sr_q, quo_sr_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_d;
    logic             no_borrow;
    logic [WIDTH:0]   prem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] mag_x, mag_y;
    logic [WIDTH-1:0] quo_fin, rem_fin;

    assign trial_a = {prem_q[WIDTH-1:0], quo_sr_q[WIDTH-1]};

    subtractor_nbits #(.WIDTH(WIDTH + 1)) u_sub (
        .x_i         (trial_a),
        .y_i         ({1'b0, dvs_q}),
        .d_o         (trial_d),
        .no_borrow_o (no_borrow)
    );

    assign prem_step = no_borrow ? trial_d : trial_a;
    assign quo_step  = {quo_sr_q[WIDTH-2:0], no_borrow};

`ifdef DIVIDER_SIGNED_EN
    logic x_neg_q, x_neg_d;
    logic q_neg_q, q_neg_d;

    assign mag_x   = dividend_i[WIDTH-1] ? (~dividend_i + WIDTH'(1)) : dividend_i;
    assign mag_y   = divisor_i[WIDTH-1]  ? (~divisor_i + WIDTH'(1))  : divisor_i;
    assign quo_fin = q_neg_q ? (~quo_step + WIDTH'(1)) : quo_step;
    assign rem_fin = x_neg_q ? (~prem_step[WIDTH-1:0] + WIDTH'(1)) : prem_step[WIDTH-1:0];
`else
    assign mag_x   = dividend_i;
    assign mag_y   = divisor_i;
    assign quo_fin = quo_step;
    assign rem_fin = prem_step[WIDTH-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        prem_d      = prem_q;
        quo_sr_d    = quo_sr_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
`ifdef DIVIDER_SIGNED_EN
        x_neg_d     = x_neg_q;
        q_neg_d     = q_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    prem_d   = '0;
                    quo_sr_d = mag_x;
                    dvs_d    = mag_y;
                    cnt_d    = CNT_INIT;
`ifdef DIVIDER_SIGNED_EN
                    x_neg_d  = dividend_i[WIDTH-1];
                    q_neg_d  = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
`endif
                    // Zero divisor skips the iterations and reports immediately.
                    if (divisor_i == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                prem_d   = prem_step;
                quo_sr_d = quo_step;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    quotient_d  = quo_fin;
                    remainder_d = rem_fin;
                    div_zero_d  = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            prem_q      <= '0;
            quo_sr_q    <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            x_neg_q     <= 1'b0;
            q_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prem_q      <= prem_d;
            quo_sr_q    <= quo_sr_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
`ifdef DIVIDER_SIGNED_EN
            x_neg_q     <= x_neg_d;
            q_neg_q     <= q_neg_d;
`endif
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign div_zero_o  = div_zero_q;

endmodule
